// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch control slice:
//   - sw_state_e : 3-bit FSM state encoding (IDLE..CLEAR)
//   - calc_div   : clock cycles per counter-chain tick
//   - calc_pw    : prescaler width needed to hold 0..DIV-1
//   - div_ok     : elaboration-time sanity check on the clock/tick ratio
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    CLEAR = 3'd4
  } sw_state_e;

  // Number of system clocks per base tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  // Prescaler width; at least 1 bit so a DIV of 2 still has a counter.
  function automatic int calc_pw(input int clk_hz, input int tick_hz);
    int div;
    div = calc_div(clk_hz, tick_hz);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

  // The tick period must be a whole number of clocks and at least two
  // clocks long, otherwise the prescaler cannot produce a single-cycle pulse.
  function automatic bit div_ok(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    return (clk_hz / tick_hz) >= 2;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// sw_prescaler
// Divides the system clock down to the counter-chain base rate.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   en   - count (stopwatch running)
//   hold - keep the current count (stopwatch paused)
//   zero - force the count back to 0 (idle / clearing)
//   tick - registered one-cycle pulse, issued the cycle after the count
//          sat at DIV-1 while enabled
module sw_prescaler #(
  parameter int DIV = 4,
  parameter int PW  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic zero,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count;

  // The count keeps the sub-tick fraction across a pause. The tick is
  // decided from the pre-edge count and enable, so a pause landing exactly
  // on the last count still delivers the tick whose period had elapsed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= en && (count == LAST);
      if (zero) begin
        count <= '0;
      end else if (en) begin
        count <= (count == LAST) ? '0 : count + 1'b1;
      end else if (!hold) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control FSM for the stopwatch counter chain. Turns debounced button
// levels into run / clear / display-hold controls and generates the
// base-rate tick for the least-significant counter.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   btn_ss    - debounced start/stop level
//   btn_lr    - debounced lap/reset level
//   chain_ovf - one-cycle overflow pulse from the most-significant counter
//   tick      - one-cycle count enable to the LS counter
//   clr       - one-cycle synchronous clear to all counters
//   disp_hold - display latch frozen (lap view)
//   running   - high in RUN or LAP
//   state     - encoded FSM state for debug/LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int STOP_ON_OVF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       chain_ovf,
  output logic       tick,
  output logic       clr,
  output logic       disp_hold,
  output logic       running,
  output logic [2:0] state
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = calc_pw(CLK_HZ, TICK_HZ);

  if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  sw_state_e state_q;
  sw_state_e state_d;
  logic      btn_ss_q;
  logic      btn_lr_q;
  logic      ss_e;
  logic      lr_e;
  logic      ovf_stop;
  logic      pre_en;
  logic      pre_hold;
  logic      pre_zero;

  // Button history resets to 1 so a button held through reset release
  // is treated as already pressed and produces no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_ss_q <= 1'b1;
      btn_lr_q <= 1'b1;
    end else begin
      btn_ss_q <= btn_ss;
      btn_lr_q <= btn_lr;
    end
  end

  assign ss_e     = btn_ss & ~btn_ss_q;
  assign lr_e     = btn_lr & ~btn_lr_q;
  assign ovf_stop = (STOP_ON_OVF != 0) && chain_ovf;

  // Next-state logic. Start/stop beats lap/reset, and any button edge
  // beats an overflow arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ss_e) state_d = RUN;
      end
      RUN: begin
        if (ss_e)          state_d = PAUSE;
        else if (lr_e)     state_d = LAP;
        else if (ovf_stop) state_d = PAUSE;
      end
      LAP: begin
        if (ss_e)          state_d = PAUSE;
        else if (lr_e)     state_d = RUN;
        else if (ovf_stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (ss_e)      state_d = RUN;
        else if (lr_e) state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus Moore outputs decoded from the next state, so the
  // registered outputs always line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clr       <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr       <= (state_d == CLEAR);
      disp_hold <= (state_d == LAP);
      running   <= (state_d == RUN) || (state_d == LAP);
    end
  end

  assign state    = state_q;
  assign pre_en   = (state_q == RUN) || (state_q == LAP);
  assign pre_hold = (state_q == PAUSE);
  assign pre_zero = (state_q == IDLE) || (state_q == CLEAR);

  sw_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .hold (pre_hold),
    .zero (pre_zero),
    .tick (tick)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Scoreboard bench for stopwatch_ctrl with DIV=4. Two instances share the
// same stimulus: one auto-pauses on overflow, the other lets the chain wrap.
// A behavioural model of each produces the expected outputs, which are
// queued when stimulus is driven and compared after the next clock edge.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 400;
  localparam int TICK_HZ = 100;
  localparam int DIV     = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       ssq;
    logic       lrq;
    logic [7:0] pre;
    logic       tick;
  } mdl_t;

  typedef struct packed {
    logic [2:0] st;
    logic       tick;
    logic       clr;
    logic       hold;
    logic       run;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } exp_pair_t;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic       chain_ovf;
  logic       tick_a, clr_a, hold_a, run_a;
  logic [2:0] state_a;
  logic       tick_b, clr_b, hold_b, run_b;
  logic [2:0] state_b;

  int checkCount;
  int passCount;

  mdl_t      ma;
  mdl_t      mb;
  exp_pair_t scoreboard[$];

  stopwatch_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .STOP_ON_OVF (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .chain_ovf (chain_ovf),
    .tick      (tick_a),
    .clr       (clr_a),
    .disp_hold (hold_a),
    .running   (run_a),
    .state     (state_a)
  );

  stopwatch_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .STOP_ON_OVF (0)
  ) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .chain_ovf (chain_ovf),
    .tick      (tick_b),
    .clr       (clr_b),
    .disp_hold (hold_b),
    .running   (run_b),
    .state     (state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state right after reset.
  function automatic mdl_t resetModel();
    mdl_t m;
    m.st   = 3'd0;
    m.ssq  = 1'b1;
    m.lrq  = 1'b1;
    m.pre  = 8'd0;
    m.tick = 1'b0;
    return m;
  endfunction

  // One clock edge of the stopwatch behaviour.
  function automatic mdl_t step(input mdl_t m, input logic ss, input logic lr,
                                input logic ovf, input bit stop);
    mdl_t n;
    logic sse, lre, isRun;
    n     = m;
    sse   = ss & ~m.ssq;
    lre   = lr & ~m.lrq;
    isRun = (m.st == 3'd1) || (m.st == 3'd2);
    n.tick = isRun && (m.pre == 8'(DIV - 1));
    if (m.st == 3'd0 || m.st == 3'd4) n.pre = 8'd0;
    else if (isRun) n.pre = (m.pre == 8'(DIV - 1)) ? 8'd0 : 8'(m.pre + 8'd1);
    case (m.st)
      3'd0: if (sse) n.st = 3'd1;
      3'd1: begin
        if (sse)              n.st = 3'd3;
        else if (lre)         n.st = 3'd2;
        else if (ovf && stop) n.st = 3'd3;
      end
      3'd2: begin
        if (sse)              n.st = 3'd3;
        else if (lre)         n.st = 3'd1;
        else if (ovf && stop) n.st = 3'd3;
      end
      3'd3: begin
        if (sse)      n.st = 3'd1;
        else if (lre) n.st = 3'd4;
      end
      default: n.st = 3'd0;
    endcase
    n.ssq = ss;
    n.lrq = lr;
    return n;
  endfunction

  function automatic exp_t toExp(input mdl_t m);
    exp_t e;
    e.st   = m.st;
    e.tick = m.tick;
    e.clr  = (m.st == 3'd4);
    e.hold = (m.st == 3'd2);
    e.run  = (m.st == 3'd1) || (m.st == 3'd2);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    else
      passCount++;
  endtask

  // Called at a falling edge: drive inputs, queue the expected result,
  // then compare just after the rising edge and return at the next fall.
  task automatic applyStimulus(input logic ss, input logic lr, input logic ovf);
    exp_pair_t e;
    btn_ss    = ss;
    btn_lr    = lr;
    chain_ovf = ovf;
    ma = step(ma, ss, lr, ovf, 1'b1);
    mb = step(mb, ss, lr, ovf, 1'b0);
    e.a = toExp(ma);
    e.b = toExp(mb);
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    e = scoreboard.pop_front();
    checkOutput("stop.state", 32'(state_a), 32'(e.a.st));
    checkOutput("stop.tick",  32'(tick_a),  32'(e.a.tick));
    checkOutput("stop.clr",   32'(clr_a),   32'(e.a.clr));
    checkOutput("stop.hold",  32'(hold_a),  32'(e.a.hold));
    checkOutput("stop.run",   32'(run_a),   32'(e.a.run));
    checkOutput("wrap.state", 32'(state_b), 32'(e.b.st));
    checkOutput("wrap.tick",  32'(tick_b),  32'(e.b.tick));
    checkOutput("wrap.clr",   32'(clr_b),   32'(e.b.clr));
    checkOutput("wrap.hold",  32'(hold_b),  32'(e.b.hold));
    checkOutput("wrap.run",   32'(run_b),   32'(e.b.run));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressSs();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressLr();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stateA"}, 32'(state_a), 32'd0);
    checkOutput({tag, ".tickA"},  32'(tick_a),  32'd0);
    checkOutput({tag, ".clrA"},   32'(clr_a),   32'd0);
    checkOutput({tag, ".holdA"},  32'(hold_a),  32'd0);
    checkOutput({tag, ".runA"},   32'(run_a),   32'd0);
    checkOutput({tag, ".stateB"}, 32'(state_b), 32'd0);
    checkOutput({tag, ".runB"},   32'(run_b),   32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b0;
    btn_ss     = 1'b1;
    btn_lr     = 1'b0;
    chain_ovf  = 1'b0;
    ma = resetModel();
    mb = resetModel();

    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Held start/stop through reset release: no event.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    // Release, then a fresh press held for several cycles: one event.
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    idle(20);

    // Pause with the prescaler at 2, wait, resume.
    for (int i = 0; i < 8; i++) begin
      if (ma.pre == 8'd2) break;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("preAlign", 32'(ma.pre == 8'd2), 32'd1);
    pressSs();
    idle(10);
    pressSs();
    idle(8);

    // Lap view and back.
    pressLr();
    idle(6);
    pressLr();
    idle(3);

    // Pause then clear.
    pressSs();
    pressLr();
    idle(4);

    // Simultaneous edges in RUN: start/stop wins.
    pressSs();
    idle(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(3);

    // Overflow in RUN: one instance pauses, the other keeps running.
    pressSs();
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(3);
    pressSs();
    pressLr();
    idle(2);
    // Overflow in LAP, and edge-versus-overflow priority.
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(2);
    pressSs();
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset between clock edges while in LAP.
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("asyncRst");
    ma = resetModel();
    mb = resetModel();
    btn_ss = 1'b0;
    btn_lr = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressSs();
    idle(6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
